modulo_fornecedor_rolhas: RTL

//  Cork supply station: the upstream end of the tray cork-buffer interface.
//  - Serves refill requests raised by the capping line when its tray buffer falls below minimum.
//  - Counts corks out of its own stock, one pulse per cork.
//  - Returns the delivered quantity with a 4-phase req/ack handshake.
//  - Keeps its own stock register, reloaded by the operator, and flags stock shortage.

---
 rtl/modulo_fornecedor_rolhas_if.sv | 34 +++
 rtl/modulo_fornecedor_rolhas.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/modulo_fornecedor_rolhas_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : modulo_fornecedor_rolhas_if
// Description : Cork-buffer link between the capping line (master) and the
//               cork supply station (slave): refill request/ack handshake,
//               tray level, operator stock load and station status.
// Revision    : 1.0 - initial release
// ============================================================================
interface modulo_fornecedor_rolhas_if;
  logic       req;
  logic [6:0] nivel_bandeja;
  logic       carga_estoque;
  logic [6:0] estoque_in;
  logic       pulso_rolha;
  logic       ack;
  logic [6:0] entregue;
  logic [6:0] estoque;
  logic       alarme_estoque;
  logic [2:0] estado;

  // Line / operator side: raises requests, reports tray level, loads stock.
  modport master (
    output req, nivel_bandeja, carga_estoque, estoque_in,
    input  pulso_rolha, ack, entregue, estoque, alarme_estoque, estado
  );

  // Supply station side.
  modport slave (
    input  req, nivel_bandeja, carga_estoque, estoque_in,
    output pulso_rolha, ack, entregue, estoque, alarme_estoque, estado
  );
endinterface
`default_nettype wire

// File: rtl/modulo_fornecedor_rolhas.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : modulo_fornecedor_rolhas
// Description : Cork supply station. Serves tray refill requests, dispensing
//               one pulse per cork every INTERVALO cycles out of its own
//               stock, and answers with a 4-phase req/ack handshake.
//               Optional macro FORNECEDOR_PARCIAL_EN: when defined, a request
//               larger than the remaining (non-zero) stock is served partially
//               and flags alarme_estoque; otherwise it goes straight to FALTA.
// Revision    : 1.0 - initial release
// ============================================================================
module modulo_fornecedor_rolhas #(
  parameter int LOTE        = 20,
  parameter int MAX_BANDEJA = 99,
  parameter int INTERVALO   = 4
) (
  input  wire logic                 clk,
  input  wire logic                 Nclr,
  modulo_fornecedor_rolhas_if.slave bus
);

  localparam int         CW          = $clog2(INTERVALO);
  localparam logic [CW-1:0] CNT_ULT  = CW'(INTERVALO - 1);
  localparam logic [6:0] LOTE_C      = 7'(LOTE);
  localparam logic [6:0] MAX_C       = 7'(MAX_BANDEJA);
  localparam logic [6:0] ESTOQUE_MAX = 7'd99;

  typedef enum logic [2:0] {
    OCIOSO   = 3'b000,
    CALC     = 3'b001,
    DISPENSA = 3'b010,
    ENTREGUE = 3'b011,
    FALTA    = 3'b100
  } estado_t;

  estado_t       estado_q,   estado_d;
  logic [6:0]    estoque_q,  estoque_d;
  logic [6:0]    entregue_q, entregue_d;
  logic [6:0]    alvo_q,     alvo_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic          pulso_q,    pulso_d;
  logic          ack_q,      ack_d;
  logic          alarme_q,   alarme_d;
`ifdef FORNECEDOR_PARCIAL_EN
  logic          parcial_q,  parcial_d;
`endif

  logic [6:0] espaco;
  logic [6:0] alvo_calc;
  logic [6:0] carga_val;
  logic [6:0] alvo_sel;
  logic       dispensa_ok;

  // Free tray space, cork target for this request and clamped stock value.
  always_comb begin
    espaco    = (bus.nivel_bandeja >= MAX_C) ? 7'd0 : (MAX_C - bus.nivel_bandeja);
    alvo_calc = (espaco < LOTE_C) ? espaco : LOTE_C;
    carga_val = (bus.estoque_in > ESTOQUE_MAX) ? ESTOQUE_MAX : bus.estoque_in;
  end

  // Next-state and next-output logic of the supply FSM.
  always_comb begin
    estado_d    = estado_q;
    estoque_d   = estoque_q;
    entregue_d  = entregue_q;
    alvo_d      = alvo_q;
    cnt_d       = cnt_q;
    pulso_d     = 1'b0;
    ack_d       = ack_q;
    alarme_d    = alarme_q;
    alvo_sel    = alvo_calc;
    dispensa_ok = 1'b0;
`ifdef FORNECEDOR_PARCIAL_EN
    parcial_d   = parcial_q;
`endif

    case (estado_q)
      OCIOSO: begin
        ack_d = 1'b0;
        // A stock load takes the cycle; a pending req is seen on the next one.
        if (bus.carga_estoque) begin
          estoque_d = carga_val;
          alarme_d  = 1'b0;
        end else if (bus.req) begin
          estado_d   = CALC;
          entregue_d = 7'd0;
        end
      end

      CALC: begin
        if (alvo_calc == 7'd0) begin
          // Tray already full: acknowledge with nothing delivered.
          estado_d = ENTREGUE;
          ack_d    = 1'b1;
        end else begin
          if (estoque_q >= alvo_calc) begin
            dispensa_ok = 1'b1;
          end
`ifdef FORNECEDOR_PARCIAL_EN
          else if (estoque_q != 7'd0) begin
            dispensa_ok = 1'b1;
            alvo_sel    = estoque_q;
            parcial_d   = 1'b1;
          end
`endif
          if (dispensa_ok) begin
            // First cork goes out on the entry cycle of DISPENSA.
            estado_d   = DISPENSA;
            alvo_d     = alvo_sel;
            cnt_d      = '0;
            pulso_d    = 1'b1;
            estoque_d  = estoque_q - 7'd1;
            entregue_d = entregue_q + 7'd1;
          end else begin
            estado_d = FALTA;
            alarme_d = 1'b1;
          end
        end
      end

      DISPENSA: begin
        if (!bus.req) begin
          // Line withdrew the request: abort, keep partial counts, no ack.
          estado_d = OCIOSO;
`ifdef FORNECEDOR_PARCIAL_EN
          parcial_d = 1'b0;
`endif
        end else if (entregue_q == alvo_q) begin
          estado_d = ENTREGUE;
          ack_d    = 1'b1;
`ifdef FORNECEDOR_PARCIAL_EN
          if (parcial_q) begin
            alarme_d = 1'b1;
          end
          parcial_d = 1'b0;
`endif
        end else if (cnt_q == CNT_ULT) begin
          cnt_d      = '0;
          pulso_d    = 1'b1;
          estoque_d  = (estoque_q != 7'd0) ? (estoque_q - 7'd1) : 7'd0;
          entregue_d = entregue_q + 7'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ENTREGUE: begin
        ack_d = 1'b1;
        if (!bus.req) begin
          estado_d = OCIOSO;
          ack_d    = 1'b0;
        end
      end

      FALTA: begin
        ack_d    = 1'b0;
        alarme_d = 1'b1;
        // Only an operator reload leaves the shortage state.
        if (bus.carga_estoque) begin
          estoque_d = carga_val;
          alarme_d  = 1'b0;
          estado_d  = OCIOSO;
        end
      end

      default: begin
        estado_d = OCIOSO;
        ack_d    = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!Nclr) begin
      estado_q   <= OCIOSO;
      estoque_q  <= 7'd0;
      entregue_q <= 7'd0;
      alvo_q     <= 7'd0;
      cnt_q      <= '0;
      pulso_q    <= 1'b0;
      ack_q      <= 1'b0;
      alarme_q   <= 1'b0;
`ifdef FORNECEDOR_PARCIAL_EN
      parcial_q  <= 1'b0;
`endif
    end else begin
      estado_q   <= estado_d;
      estoque_q  <= estoque_d;
      entregue_q <= entregue_d;
      alvo_q     <= alvo_d;
      cnt_q      <= cnt_d;
      pulso_q    <= pulso_d;
      ack_q      <= ack_d;
      alarme_q   <= alarme_d;
`ifdef FORNECEDOR_PARCIAL_EN
      parcial_q  <= parcial_d;
`endif
    end
  end

  assign bus.pulso_rolha    = pulso_q;
  assign bus.ack            = ack_q;
  assign bus.entregue       = entregue_q;
  assign bus.estoque        = estoque_q;
  assign bus.alarme_estoque = alarme_q;
  assign bus.estado         = estado_q;

endmodule
`default_nettype wire
